// File: rtl/gactx_bank3_example_stream_alu.sv
`default_nettype none
// ============================================================================
//  Module   : gactx_bank3_example_stream_alu
//  Brief    : Lane-parallel streaming ALU (add / sub / unsigned max / pass)
//             with a start/busy/done control FSM, an elastic fixed-latency
//             pipeline and counter-derived output tlast.
//  Revision : 1.0 - initial release
// ============================================================================
module gactx_bank3_example_stream_alu #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ELEM_WIDTH       = 32,
  parameter int C_PIPE_STAGES      = 2,
  parameter int C_SATURATE         = 0
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  input  logic                          ctrl_start,
  input  logic [1:0]                    ctrl_mode,
  input  logic [C_ELEM_WIDTH-1:0]       ctrl_constant,
  input  logic [31:0]                   ctrl_num_beats,
  output logic                          ctrl_busy,
  output logic                          ctrl_done,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          stat_tlast_err
);

  localparam int N_LANES = C_AXIS_TDATA_WIDTH / C_ELEM_WIDTH;
  localparam int W       = C_ELEM_WIDTH;

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_MAX = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                          state;
  state_t                          state_nxt;
  logic [1:0]                      rst_sync;
  logic [1:0]                      mode_q;
  logic [W-1:0]                    const_q;
  logic [31:0]                     num_q;
  logic [31:0]                     in_cnt;
  logic                            advance;
  logic                            s_fire;
  logic                            m_fire;
  logic                            in_last;
  logic                            start_fire;
  logic [C_AXIS_TDATA_WIDTH-1:0]   alu_out;
  logic [C_AXIS_TDATA_WIDTH-1:0]   pipe_data [C_PIPE_STAGES];
  logic [C_PIPE_STAGES-1:0]        pipe_valid;
  logic [C_PIPE_STAGES-1:0]        pipe_last;

  // Release of reset is re-timed to aclk; assertion stays asynchronous.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign advance       = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == RUN) && advance;
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign m_fire        = m_axis_tvalid && m_axis_tready;
  // Only meaningful in RUN, where num_q is known to be non-zero.
  assign in_last       = (in_cnt == (num_q - 32'd1));
  // Starts are honoured only once the synchronised reset release has landed.
  assign start_fire    = (state == IDLE) && ctrl_start && rst_sync[1];

  assign ctrl_busy     = (state != IDLE);
  assign ctrl_done     = (state == DONE);
  assign m_axis_tvalid = pipe_valid[C_PIPE_STAGES-1];
  assign m_axis_tlast  = pipe_last[C_PIPE_STAGES-1];
  assign m_axis_tdata  = pipe_data[C_PIPE_STAGES-1];

  // Per-lane arithmetic on the incoming beat using the latched operation.
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic [W-1:0] a;
    logic [W:0]   sum;
    logic [W:0]   diff;
    logic [W-1:0] res;

    assign a    = s_axis_tdata[i*W +: W];
    assign sum  = {1'b0, a} + {1'b0, const_q};
    assign diff = {1'b0, a} - {1'b0, const_q};

    // Select the lane result; the carry/borrow bit drives saturation.
    always_comb begin
      res = a;
      case (mode_q)
        MODE_ADD: res = ((C_SATURATE != 0) && sum[W])  ? {W{1'b1}} : sum[W-1:0];
        MODE_SUB: res = ((C_SATURATE != 0) && diff[W]) ? {W{1'b0}} : diff[W-1:0];
        MODE_MAX: res = (a > const_q) ? a : const_q;
        default:  res = a;
      endcase
    end

    assign alu_out[i*W +: W] = res;
  end

  // State register.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_fire) state_nxt = (ctrl_num_beats == 32'd0) ? DONE : RUN;
      RUN:     if (s_fire && in_last) state_nxt = DRAIN;
      DRAIN:   if (m_fire && m_axis_tlast) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job parameters, input beat counter and the sticky tlast-mismatch flag.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      mode_q         <= 2'd0;
      const_q        <= '0;
      num_q          <= 32'd0;
      in_cnt         <= 32'd0;
      stat_tlast_err <= 1'b0;
    end else if (start_fire) begin
      mode_q         <= ctrl_mode;
      const_q        <= ctrl_constant;
      num_q          <= ctrl_num_beats;
      in_cnt         <= 32'd0;
      stat_tlast_err <= 1'b0;
    end else if (s_fire) begin
      in_cnt <= in_cnt + 32'd1;
      if (s_axis_tlast != in_last) begin
        stat_tlast_err <= 1'b1;
      end
    end
  end

  // Lock-step pipeline: every stage moves together whenever the output can take a beat.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
      for (int k = 0; k < C_PIPE_STAGES; k++) begin
        pipe_data[k] <= '0;
      end
    end else if (advance) begin
      pipe_valid[0] <= s_fire;
      pipe_last[0]  <= s_fire && in_last;
      pipe_data[0]  <= alu_out;
      for (int k = 1; k < C_PIPE_STAGES; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_last[k]  <= pipe_last[k-1];
        pipe_data[k]  <= pipe_data[k-1];
      end
    end
  end

endmodule
`default_nettype wire
